// File: rtl/timer_device.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, a four-state count FSM,
// and an interrupt request gated by the CTRL interrupt mask.
module timer_device (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        flag_q, flag_d;

    logic wr_ctrl, wr_preset, en, reload;
    logic fsm_set, fsm_clr, fsm_en_clr;

    assign wr_ctrl   = we && (addr == 2'b00);
    assign wr_preset = we && (addr == 2'b01);
    assign en        = ctrl_q[0];
    assign reload    = (ctrl_q[2:1] == 2'b01);

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        flag_d     = flag_q;
        fsm_set    = 1'b0;
        fsm_clr    = 1'b0;
        fsm_en_clr = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_LOAD;
            end
            S_LOAD: begin
                count_d = preset_q;
                fsm_clr = 1'b1;
                state_d = en ? S_CNT : S_IDLE;
            end
            S_CNT: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = 32'd0;
                    fsm_set = 1'b1;
                    state_d = S_INT;
                end
            end
            S_INT: begin
                // Clearing the flag on the way back into LOAD keeps the reload pulse one cycle wide.
                if (reload) begin
                    fsm_clr = 1'b1;
                    state_d = S_LOAD;
                end else begin
                    fsm_en_clr = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fsm_en_clr) ctrl_d[0] = 1'b0;
        if (wr_ctrl)    ctrl_d    = wd[3:0];
        if (wr_preset)  preset_d  = wd;

        // CTRL write clears above all; the expiry set outranks a PRESET write.
        if (wr_ctrl)        flag_d = 1'b0;
        else if (fsm_set)   flag_d = 1'b1;
        else if (wr_preset) flag_d = 1'b0;
        else if (fsm_clr)   flag_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        case (addr)
            2'b00:   rd = {28'd0, ctrl_q};
            2'b01:   rd = preset_q;
            2'b10:   rd = count_q;
            default: rd = 32'd0;
        endcase
    end

    assign irq = ctrl_q[3] & flag_q;

endmodule

// File: tb/tb_timer_device.sv
// Bench for timer_device: directed scenarios with literal expectations plus randomized
// register traffic, all checked every cycle against a behavioural model.
module tb_timer_device;

    logic        clk;
    logic        clk_run;
    logic        rst_n;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    timer_device dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .we    (we),
        .wd    (wd),
        .rd    (rd),
        .irq   (irq)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    // behavioural model: stage 0 idle, 1 about to load, 2 counting down, 3 expired
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;
    int          m_stage;

    task automatic model_reset();
        m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0; m_stage = 0;
    endtask

    task automatic model_edge(input logic [1:0] a, input logic w, input logic [31:0] d);
        logic [3:0]  c;
        logic [31:0] n;
        logic        f;
        logic        expired;
        int          s;
        c = m_ctrl; n = m_count; f = m_flag; s = m_stage; expired = 1'b0;
        if (m_stage == 0) begin
            if (m_ctrl[0]) s = 1;
        end else if (m_stage == 1) begin
            n = m_preset;
            f = 1'b0;
            s = m_ctrl[0] ? 2 : 0;
        end else if (m_stage == 2) begin
            if (!m_ctrl[0]) s = 0;
            else if (m_count >= 2) n = m_count - 1;
            else begin n = 0; f = 1'b1; expired = 1'b1; s = 3; end
        end else begin
            if (m_ctrl[2:1] == 2'b01) begin s = 1; f = 1'b0; end
            else begin c[0] = 1'b0; s = 0; end
        end
        if (w && a == 2'd1) begin
            m_preset = d;
            if (!expired) f = 1'b0;
        end
        if (w && a == 2'd0) begin
            c = d[3:0];
            f = 1'b0;
        end
        m_ctrl = c; m_count = n; m_flag = f; m_stage = s;
    endtask

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        if (a == 2'd0)      return {28'd0, m_ctrl};
        else if (a == 2'd1) return m_preset;
        else if (a == 2'd2) return m_count;
        return 32'd0;
    endfunction

    function automatic logic model_irq();
        return m_ctrl[3] & m_flag;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_edge(addr, we, wd);
        end
    end

    // scoreboard
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("cycle_rd", rd, model_rd(addr));
            check("cycle_irq", {31'd0, irq}, {31'd0, model_irq()});
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [1:0] a, input logic [31:0] d);
        addr = a; we = 1'b1; wd = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, rd, exp);
    endtask

    initial begin
        clk_run = 1'b0;
        rst_n = 1'b0; addr = 2'd0; we = 1'b0; wd = 32'd0;

        // 1 reset with no clock
        #20;
        for (int a = 0; a < 4; a++) read_check("reset_rd", 2'(a), 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        #3;
        clk_run = 1'b1;
        tick(3);
        read_check("idle_count", 2'd2, 32'd0);
        read_check("idle_ctrl", 2'd0, 32'd0);

        // 2 one-shot
        write(2'd1, 32'd5);
        write(2'd0, 32'h9);
        tick(6);
        check("os_irq_e6", {31'd0, irq}, 32'd0);
        tick(1);
        check("os_irq_e7", {31'd0, irq}, 32'd1);
        check("os_model_e7", {31'd0, model_irq()}, 32'd1);
        tick(1);
        read_check("os_ctrl", 2'd0, 32'h8);
        read_check("os_count", 2'd2, 32'd0);
        tick(3);
        check("os_irq_hold", {31'd0, irq}, 32'd1);
        write(2'd0, 32'h8);
        check("os_irq_clr", {31'd0, irq}, 32'd0);

        // 3 auto-reload
        write(2'd1, 32'd3);
        write(2'd0, 32'hB);
        addr = 2'd2;
        for (int e = 1; e <= 16; e++) begin
            tick(1);
            check("ar_irq", {31'd0, irq}, (e == 5 || e == 10 || e == 15) ? 32'd1 : 32'd0);
            if (e >= 7 && e <= 10) check("ar_count", rd, 32'(10 - e));
        end
        write(2'd0, 32'h0);
        tick(2);

        // 4 disable mid-count
        write(2'd1, 32'd100);
        write(2'd0, 32'h9);
        tick(19);
        write(2'd0, 32'h8);
        tick(1);
        read_check("dis_count", 2'd2, 32'd82);
        check("dis_model", m_count, 32'd82);
        tick(10);
        read_check("dis_frozen", 2'd2, 32'd82);
        check("dis_irq", {31'd0, irq}, 32'd0);

        // 5 masked
        write(2'd1, 32'd2);
        write(2'd0, 32'h1);
        tick(4);
        read_check("mask_count", 2'd2, 32'd0);
        read_check("mask_ctrl_e4", 2'd0, 32'h1);
        check("mask_irq", {31'd0, irq}, 32'd0);
        tick(1);
        read_check("mask_ctrl_e5", 2'd0, 32'h0);

        // 6 register access
        write(2'd2, 32'h1234);
        write(2'd3, 32'h5678);
        read_check("ign_count", 2'd2, 32'd0);
        read_check("ign_preset", 2'd1, 32'd2);
        write(2'd1, 32'hDEADBEEF);
        read_check("preset_rb", 2'd1, 32'hDEADBEEF);
        write(2'd0, 32'hFFFFFFFF);
        read_check("ctrl_rb", 2'd0, 32'h0000000F);
        read_check("unused_rd", 2'd3, 32'd0);
        write(2'd0, 32'h0);
        tick(2);

        // randomized traffic with one asynchronous reset in the middle
        for (int i = 0; i < 3000; i++) begin
            addr = 2'($urandom_range(0, 3));
            we   = ($urandom_range(0, 9) == 0);
            if (addr == 2'd1) wd = $urandom_range(0, 10);
            else begin
                wd = $urandom;
                wd[0] = ($urandom_range(0, 3) != 0);
            end
            if (i == 1500) begin
                we = 1'b0;
                #2;
                rst_n = 1'b0;
                #1;
                check("async_irq", {31'd0, irq}, 32'd0);
                addr = 2'd2;
                #1;
                check("async_count", rd, 32'd0);
                @(negedge clk);
                #1;
                rst_n = 1'b1;
            end
            tick(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
